// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution MAC engine.
package conv_pkg;

  // Frame-level engine states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  // Default geometry of the engine.
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TAPS      = 9;
  localparam int DEF_FRAC_BITS = 24;
  localparam int DEF_GUARD_W   = 8;

  // Fixed-point 1.0 in the default format.
  localparam logic [DEF_DATA_W-1:0] FIX_ONE = DEF_DATA_W'(1) << DEF_FRAC_BITS;

endpackage

// File: rtl/conv_coef_bank.sv
// Coefficient register file: TAPS words, single write port, combinational read.
module conv_coef_bank #(
  parameter int DATA_W = 32,
  parameter int TAPS   = 9,
  parameter int IDX_W  = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] coef_q [TAPS];
  logic [DATA_W-1:0] coef_d [TAPS];

  // Next-state of the register file: copy, then overwrite the addressed word.
  always_comb begin
    // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
    coef_d = coef_q;
    if (we) coef_d[idx] = wdata;
  end

  // Coefficient storage; cleared on reset so an unloaded engine computes zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this small register file is reset on purpose (unloaded coefficients must read 0); large RAMs normally are not.
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else begin
      coef_q <= coef_d;
    end
  end

  assign rdata = coef_q[idx];

endmodule

// File: rtl/conv_mac_engine.sv
// Streaming fixed-point convolution MAC: loads a kernel, then accumulates
// one TAPS-long sample frame into a single rounded-down, optionally
// ReLU'd and saturated result.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAPS      = DEF_TAPS,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int GUARD_W   = DEF_GUARD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_coef,
  input  logic              clear,
  input  logic              relu_en,
  input  logic              sat_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              coef_ok,
  output logic              busy
);

  localparam int ACC_W = DATA_W + GUARD_W;
  localparam int EXT_W = 2 * DATA_W + GUARD_W;
  localparam int IDX_W = $clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(GUARD_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(GUARD_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      coef_ok_q, coef_ok_d;
  logic                      relu_q, relu_d;
  logic                      sat_q, sat_d;

  logic                      xfer;
  logic                      coef_we;
  logic [DATA_W-1:0]         coef_rd;
  logic [2*DATA_W-1:0]       prod;
  logic signed [EXT_W-1:0]   prod_ext;
  logic signed [EXT_W-1:0]   prod_sh;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   acc_relu;
  logic [DATA_W-1:0]         result;

  conv_coef_bank #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .IDX_W  (IDX_W)
  ) u_coef_bank (
    .clk   (clk),
    .reset (reset),
    .we    (coef_we),
    .idx   (idx_q),
    .wdata (in_data),
    .rdata (coef_rd)
  );

  assign in_ready = reset && (state_q != ST_OUTPUT);
  assign xfer     = in_valid && in_ready;

  // Signed DATA_W x DATA_W product (low 2*DATA_W bits of the sign-extended
  // operands), floor-shifted to the accumulator's fixed-point scale.
  always_comb begin
    prod     = {{DATA_W{in_data[DATA_W-1]}}, in_data} * {{DATA_W{coef_rd[DATA_W-1]}}, coef_rd};
    prod_ext = $signed({{GUARD_W{prod[2*DATA_W-1]}}, prod});
    prod_sh  = prod_ext >>> FRAC_BITS;
    term     = prod_sh[ACC_W-1:0];
    acc_sum  = acc_q + term;
  end

  // Output shaping of the final sum: ReLU first, then saturate or truncate.
  always_comb begin
    acc_relu = (relu_q && acc_sum[ACC_W-1]) ? '0 : acc_sum;
    result   = acc_relu[DATA_W-1:0];
    if (sat_q) begin
      if (acc_relu > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
      else if (acc_relu < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
    end
  end

  // Frame sequencing: state, tap index, accumulator and result registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    coef_ok_d   = coef_ok_q;
    relu_d      = relu_q;
    sat_d       = sat_q;
    coef_we     = 1'b0;

    if (clear) begin
      // Abort wins over any transfer presented in the same cycle.
      state_d     = ST_IDLE;
      idx_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            // Frame mode and output shaping are latched only here.
            relu_d = relu_en;
            sat_d  = sat_en;
            idx_d  = IDX_W'(1);
            if (load_coef) begin
              coef_we = 1'b1;
              state_d = ST_LOAD;
            end else begin
              acc_d   = term;
              state_d = ST_ACCUM;
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            coef_we = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d     = '0;
              coef_ok_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        ST_ACCUM: begin
          if (xfer) begin
            acc_d = acc_sum;
            if (idx_q == LAST_IDX) begin
              idx_d       = '0;
              out_data_d  = result;
              out_valid_d = 1'b1;
              state_d     = ST_OUTPUT;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      coef_ok_q   <= 1'b0;
      relu_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      coef_ok_q   <= coef_ok_d;
      relu_q      <= relu_d;
      sat_q       <= sat_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign coef_ok   = coef_ok_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench for conv_mac_engine: directed frames push expected
// results; a negedge monitor pops and compares each accepted output.
module tb_conv_mac_engine;
  import conv_pkg::*;

  localparam int TAPS = 9;
  localparam logic [31:0] NEG_ONE = 32'hFF00_0000;
  localparam logic [31:0] BIG     = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        load_coef;
  logic        clear;
  logic        relu_en;
  logic        sat_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        coef_ok;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  conv_mac_engine dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_coef (load_coef),
    .clear     (clear),
    .relu_en   (relu_en),
    .sat_en    (sat_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coef_ok   (coef_ok),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared with the oldest expectation.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
      else                   check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
  end

  // Present one word until accepted, with optional random bubbles.
  task automatic push_word(input logic [31:0] d, input int bubble_pct);
    int t = 0;
    bit done = 1'b0;
    in_data = d;
    while (!done && t < 100) begin
      in_valid = ($urandom_range(99) >= bubble_pct);
      done     = in_valid && in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!done) check("in_accept_timeout", 64'(t), 64'd0);
  endtask

  // Send n words; mode/shaping inputs are inverted after the first word,
  // which the engine must ignore.
  task automatic run_frame(input bit load, input logic [31:0] base, input bit ramp,
                           input int n, input bit relu, input bit sat, input int bubble_pct);
    load_coef = load;
    relu_en   = relu;
    sat_en    = sat;
    for (int k = 0; k < n; k++) begin
      if (!load && n == TAPS && k == TAPS - 1) check("no_early_valid", 64'(out_valid), 64'd0);
      push_word(ramp ? base + 32'(k) : base, bubble_pct);
      load_coef = ~load;
      relu_en   = ~relu;
      sat_en    = ~sat;
    end
    load_coef = 1'b0;
    relu_en   = 1'b0;
    sat_en    = 1'b0;
  endtask

  task automatic load_all(input logic [31:0] c, input int bubble_pct);
    run_frame(1'b1, c, 1'b0, TAPS, 1'b0, 1'b0, bubble_pct);
    check("coef_ok_after_load", 64'(coef_ok), 64'd1);
    check("idle_after_load", 64'(busy), 64'd0);
  endtask

  task automatic compute(input logic [31:0] base, input bit ramp, input bit relu,
                         input bit sat, input logic [31:0] exp, input int bubble_pct);
    exp_q.push_back(exp);
    run_frame(1'b0, base, ramp, TAPS, relu, sat, bubble_pct);
    check("out_valid_latency", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    load_coef = 1'b0;
    clear     = 1'b0;
    relu_en   = 1'b0;
    sat_en    = 1'b0;
    out_ready = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_coef_ok", 64'(coef_ok), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Unloaded coefficients: result 0.
    compute(32'd1, 1'b1, 1'b0, 1'b1, 32'd0, 0);
    drain();
    check("coef_ok_unloaded", 64'(coef_ok), 64'd0);

    // 1.0 kernel, samples 1..9 -> 45.
    load_all(FIX_ONE, 0);
    compute(32'd1, 1'b1, 1'b0, 1'b1, 32'd45, 0);
    drain();

    // -1.0 kernel -> -45, and 0 with ReLU.
    load_all(NEG_ONE, 0);
    compute(32'd1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFD3, 0);
    compute(32'd1, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 0);
    drain();

    // Large operands: accumulator 0x3F_FFFF_F700.
    load_all(BIG, 0);
    compute(BIG, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 0);
    compute(BIG, 1'b0, 1'b0, 1'b0, 32'hFFFF_F700, 0);
    drain();

    // Output back-pressure: result held for 5 cycles.
    load_all(FIX_ONE, 0);
    out_ready = 1'b0;
    compute(32'd1, 1'b1, 1'b0, 1'b0, 32'd45, 0);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_data", 64'(out_data), 64'd45);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_busy", 64'(busy), 64'd0);
    check("release_popped", 64'(exp_q.size()), 64'd0);

    // Reset mid-frame: everything back to zero, kernel lost.
    run_frame(1'b0, 32'd1, 1'b1, 4, 1'b0, 1'b0, 0);
    check("midframe_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_coef_ok", 64'(coef_ok), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    compute(32'd1, 1'b1, 1'b0, 1'b1, 32'd0, 0);
    drain();

    // Clear mid-frame with a simultaneous transfer: kernel kept, frame restarts.
    load_all(FIX_ONE, 0);
    run_frame(1'b0, 32'd1, 1'b1, 4, 1'b0, 1'b0, 0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd100;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_coef_ok", 64'(coef_ok), 64'd1);
    compute(32'd1, 1'b1, 1'b0, 1'b1, 32'd45, 0);
    drain();

    // Random bubbles during load and compute.
    load_all(NEG_ONE, 50);
    load_all(FIX_ONE, 50);
    compute(32'd1, 1'b1, 1'b0, 1'b1, 32'd45, 50);
    compute(32'd1, 1'b1, 1'b1, 1'b0, 32'd45, 50);
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
